// File: rtl/prog_seq_pkg.sv
// Shared definitions for the TIS-100 node program sequencer.
//  - OP_* : decoded opcode classes presented on the instr input
//  - state_e : sequencer FSM states (RUN executes, LOAD accepts program words)
//  - clamp_len : maps a requested program length onto 1..depth
package prog_seq_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPC_W-1:0] OP_JMP = 4'd8;
    localparam logic [OPC_W-1:0] OP_JEZ = 4'd9;
    localparam logic [OPC_W-1:0] OP_JNZ = 4'd10;
    localparam logic [OPC_W-1:0] OP_JGZ = 4'd11;
    localparam logic [OPC_W-1:0] OP_JLZ = 4'd12;
    localparam logic [OPC_W-1:0] OP_JRO = 4'd13;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // An empty program still needs one slot; longer than memory is capped.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned depth);
        if (len == 0) begin
            return 1;
        end else if (len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/prog_seq_mem.sv
// Program memory: DEPTH x OP_W words, one synchronous write port and one
// asynchronous read port. Contents are never cleared by reset.
//  clk    in  clock
//  we     in  write strobe (already range-checked by the caller)
//  waddr  in  write address
//  wdata  in  write data
//  raddr  in  read address
//  rdata  out mem[raddr], combinational
module prog_seq_mem #(
    parameter int unsigned OP_W          = 21,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DEPTH         = 32,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OP_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OP_W-1:0]   rdata
);

    logic [OP_W-1:0] mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Zero-latency read so the opcode tracks the PC within the same cycle.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_seq.sv
// Program sequencer for one TIS-100 execution node: program memory plus PC,
// with runtime program load, runtime program length and a port-stall hold.
//  clk, reset   clock, synchronous active-high reset
//  clk_en       node step enable
//  stall        node blocked on a port; freezes the PC
//  instr        decoded opcode class of the current instruction
//  acc          signed accumulator (conditional jumps)
//  jmp_off      signed PC-relative jump offset
//  prog_we      program write strobe (enters LOAD from RUN)
//  prog_addr    program write address
//  prog_data    program write data
//  prog_commit  end of load: latch prog_len, restart at pc 0
//  prog_len     requested program length
//  opcode       mem[pc], combinational
//  opcode_vld   high while running, low while loading
//  pc           current program counter
module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int unsigned OP_W          = 21,
    parameter int unsigned DATA_W        = 11,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned NUM_ENTRIES   = 10,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              stall,
    input  logic [OPC_W-1:0]  instr,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] jmp_off,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [OP_W-1:0]   prog_data,
    input  logic              prog_commit,
    input  logic [ADDR_W:0]   prog_len,
    output logic [OP_W-1:0]   opcode,
    output logic              opcode_vld,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned LW = ADDR_W + 1;
    // Wide enough that pc + offset never overflows and keeps a sign bit.
    localparam int unsigned TW = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LW-1:0]     len_q, len_d;

    logic              mem_we;
    logic              jmp_en;
    logic signed [DATA_W-1:0] off_s;
    logic signed [TW-1:0]     pc_ext, off_ext, len_ext, tgt;

    // Out-of-range writes are dropped; reset suppresses writes as well.
    assign mem_we = prog_we && !reset && (32'(prog_addr) < DEPTH);

    prog_seq_mem #(
        .OP_W         (OP_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .MEM_INIT_FILE(MEM_INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc_q),
        .rdata(opcode)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: commit always returns to RUN, a write while running starts a load.
    always_comb begin
        state_d = state_q;
        if (prog_commit) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && prog_we) begin
            state_d = ST_LOAD;
        end
    end

    // FSM outputs.
    always_comb begin
        opcode_vld = 1'b1;
        if (state_q == ST_LOAD) begin
            opcode_vld = 1'b0;
        end
    end

    // Jump condition on the signed accumulator.
    always_comb begin
        jmp_en = 1'b0;
        case (instr)
            OP_JMP:  jmp_en = 1'b1;
            OP_JRO:  jmp_en = 1'b1;
            OP_JEZ:  jmp_en = (acc == '0);
            OP_JNZ:  jmp_en = (acc != '0);
            OP_JGZ:  jmp_en = !acc[DATA_W-1] && (acc != '0);
            OP_JLZ:  jmp_en = acc[DATA_W-1];
            default: jmp_en = 1'b0;
        endcase
    end

    // Jump target: zero-extended pc plus sign-extended offset.
    always_comb begin
        off_s   = signed'(jmp_off);
        pc_ext  = signed'(TW'(pc_q));
        off_ext = TW'(off_s);
        len_ext = signed'(TW'(len_q));
        tgt     = pc_ext + off_ext;
    end

    // PC and program-length next values.
    always_comb begin
        pc_d  = pc_q;
        len_d = len_q;
        if (prog_commit) begin
            pc_d  = '0;
            len_d = LW'(clamp_len(32'(prog_len), DEPTH));
        end else if ((state_q == ST_LOAD) || prog_we) begin
            pc_d = '0;
        end else if (clk_en && !stall) begin
            if (jmp_en) begin
                if (tgt < 0) begin
                    pc_d = '0;
                end else if (tgt >= len_ext) begin
                    pc_d = ADDR_W'(len_q - LW'(1));
                end else begin
                    pc_d = ADDR_W'(tgt);
                end
            end else if ((LW'(pc_q) + LW'(1)) >= len_q) begin
                // Covers both the normal wrap and a pc left beyond a shrunk length.
                pc_d = '0;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // PC and length registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            len_q <= LW'(NUM_ENTRIES);
        end else begin
            pc_q  <= pc_d;
            len_q <= len_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_prog_seq.sv
module tb_prog_seq;
    import prog_seq_pkg::*;

    localparam int unsigned OP_W        = 21;
    localparam int unsigned DATA_W      = 11;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DEPTH       = 32;
    localparam int unsigned NUM_ENTRIES = 10;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clk_en;
    logic                     stall;
    logic [OPC_W-1:0]         instr;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] jmp_off;
    logic                     prog_we;
    logic [ADDR_W-1:0]        prog_addr;
    logic [OP_W-1:0]          prog_data;
    logic                     prog_commit;
    logic [ADDR_W:0]          prog_len;
    logic [OP_W-1:0]          opcode;
    logic                     opcode_vld;
    logic [ADDR_W-1:0]        pc;

    prog_seq #(
        .OP_W(OP_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .NUM_ENTRIES(NUM_ENTRIES), .MEM_INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .stall(stall), .instr(instr),
        .acc(acc), .jmp_off(jmp_off), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_commit(prog_commit), .prog_len(prog_len),
        .opcode(opcode), .opcode_vld(opcode_vld), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              pc;
        bit              vld;
        logic [OP_W-1:0] op;
        bit              known;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: program counter behaviour as plain integer arithmetic.
    int              m_pc  = 0;
    int              m_len = NUM_ENTRIES;
    bit              m_run = 1'b1;
    logic [OP_W-1:0] m_mem   [DEPTH];
    bit              m_known [DEPTH];

    task automatic model_step();
        exp_t e;
        int   a;
        int   t;
        bit   jump;
        if (reset) begin
            m_run = 1'b1;
            m_pc  = 0;
            m_len = NUM_ENTRIES;
        end else begin
            if (prog_we && int'(prog_addr) < int'(DEPTH)) begin
                m_mem[prog_addr]   = prog_data;
                m_known[prog_addr] = 1'b1;
            end
            if (prog_commit) begin
                m_len = (prog_len == 0) ? 1 : (int'(prog_len) > int'(DEPTH)) ? DEPTH : int'(prog_len);
                m_pc  = 0;
                m_run = 1'b1;
            end else if (!m_run) begin
                m_pc = 0;
            end else if (prog_we) begin
                m_run = 1'b0;
                m_pc  = 0;
            end else if (clk_en && !stall) begin
                a = acc;
                case (instr)
                    OP_JMP, OP_JRO: jump = 1'b1;
                    OP_JEZ:  jump = (a == 0);
                    OP_JNZ:  jump = (a != 0);
                    OP_JGZ:  jump = (a > 0);
                    OP_JLZ:  jump = (a < 0);
                    default: jump = 1'b0;
                endcase
                if (jump) begin
                    t = m_pc + int'(jmp_off);
                    if (t < 0)           m_pc = 0;
                    else if (t >= m_len) m_pc = m_len - 1;
                    else                 m_pc = t;
                end else begin
                    m_pc = (m_pc + 1 >= m_len) ? 0 : m_pc + 1;
                end
            end
        end
        e.pc    = m_pc;
        e.vld   = m_run;
        e.op    = m_mem[m_pc];
        e.known = m_known[m_pc];
        exp_q.push_back(e);
    endtask

    // One clock: predict post-edge outputs, then advance to the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; clk_en = 0; stall = 0; instr = OP_NOP; acc = '0; jmp_off = '0;
        prog_we = 0; prog_addr = '0; prog_data = '0; prog_commit = 0; prog_len = '0;
    endtask

    task automatic step_op(input logic [OPC_W-1:0] op, input int a, input int off);
        idle();
        clk_en = 1; instr = op; acc = DATA_W'(a); jmp_off = DATA_W'(off);
        tick();
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 1;
        repeat (n) tick();
        reset = 0;
    endtask

    function automatic logic [OPC_W-1:0] pick_op(input int k);
        case (k)
            0: return OP_JMP;
            1: return OP_JRO;
            2: return OP_JEZ;
            3: return OP_JNZ;
            4: return OP_JGZ;
            5: return OP_JLZ;
            default: return OP_NOP;
        endcase
    endfunction

    // Monitor: outputs are always presented, so one expectation is consumed per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (pc !== ADDR_W'(e.pc)) begin
                    n_bad++;
                    $display("FAIL pc cyc=%0d got=%0d exp=%0d", cyc, pc, e.pc);
                end
                n_cmp++;
                if (opcode_vld !== e.vld) begin
                    n_bad++;
                    $display("FAIL opcode_vld cyc=%0d got=%0b exp=%0b", cyc, opcode_vld, e.vld);
                end
                if (e.known) begin
                    n_cmp++;
                    if (opcode !== e.op) begin
                        n_bad++;
                        $display("FAIL opcode cyc=%0d pc=%0d got=%h exp=%h", cyc, pc, opcode, e.op);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        idle();

        // Reset and free run over the default length.
        do_reset(2);
        repeat (12) step_op(OP_NOP, 0, 0);

        // Unconditional jumps with clamping and the JRO 0 halt.
        do_reset(1);
        repeat (3) step_op(OP_NOP, 0, 0);
        step_op(OP_JMP, 0, -5);
        repeat (3) step_op(OP_NOP, 0, 0);
        step_op(OP_JMP, 0, 20);
        do_reset(1);
        repeat (3) step_op(OP_NOP, 0, 0);
        repeat (3) step_op(OP_JRO, 0, 0);

        // Conditional jumps, including the most negative accumulator.
        do_reset(1);
        repeat (4) step_op(OP_NOP, 0, 0);
        step_op(OP_JGZ, -1, 3);
        step_op(OP_JLZ, -1, 2);
        step_op(OP_JNZ, 0, 1);
        step_op(OP_JLZ, -1024, -3);
        step_op(OP_JEZ, 0, 4);
        step_op(OP_JGZ, 1023, -2);

        // Stall holds the PC and ignores the jump until released.
        do_reset(1);
        step_op(OP_NOP, 0, 0);
        repeat (3) begin
            idle(); clk_en = 1; stall = 1; instr = OP_JMP; jmp_off = DATA_W'(5);
            tick();
        end
        step_op(OP_JMP, 0, 5);

        // Load four words, commit on the last write, run and wrap.
        for (int i = 0; i < 4; i++) begin
            idle();
            prog_we = 1; prog_addr = ADDR_W'(i); prog_data = OP_W'($urandom);
            if (i == 3) begin
                prog_commit = 1; prog_len = 6'd4;
            end
            tick();
        end
        repeat (6) step_op(OP_NOP, 0, 0);

        // Length clamping from a RUN-state commit.
        idle(); prog_commit = 1; prog_len = 6'd0; tick();
        repeat (3) step_op(OP_NOP, 0, 0);
        step_op(OP_JMP, 0, 7);
        idle(); prog_commit = 1; prog_len = 6'd40; tick();
        repeat (34) step_op(OP_NOP, 0, 0);

        // Reset in the middle of a load keeps the written words.
        for (int i = 0; i < 2; i++) begin
            idle(); prog_we = 1; prog_addr = ADDR_W'(i); prog_data = OP_W'($urandom); tick();
        end
        do_reset(1);
        repeat (3) step_op(OP_NOP, 0, 0);

        // Fill the whole memory so every later opcode is checkable.
        for (int i = 0; i < int'(DEPTH); i++) begin
            idle(); prog_we = 1; prog_addr = ADDR_W'(i); prog_data = OP_W'($urandom); tick();
        end
        idle(); prog_commit = 1; prog_len = 6'd20; tick();

        // Randomised operation.
        for (int n = 0; n < 1500; n++) begin
            idle();
            reset  = ($urandom_range(0, 199) == 0);
            clk_en = ($urandom_range(0, 3) != 0);
            stall  = ($urandom_range(0, 4) == 0);
            instr  = pick_op(int'($urandom_range(0, 9)));
            r = int'($urandom_range(0, 5));
            acc = (r == 0) ? DATA_W'(0) : (r == 1) ? DATA_W'(-1024) : DATA_W'($urandom);
            r = int'($urandom_range(0, 4));
            jmp_off = (r == 0) ? DATA_W'($urandom) : DATA_W'(int'($urandom_range(0, 80)) - 40);
            if (m_run) begin
                prog_we     = ($urandom_range(0, 39) == 0);
                prog_commit = ($urandom_range(0, 59) == 0);
            end else begin
                prog_we     = ($urandom_range(0, 1) == 0);
                prog_commit = ($urandom_range(0, 4) == 0);
            end
            prog_addr = ADDR_W'($urandom);
            prog_data = OP_W'($urandom);
            prog_len  = ADDR_W'(0) + 6'($urandom_range(0, 40));
            tick();
        end

        idle();
        tick();
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
